// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU and its iterative multiply/divide unit.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_AND   = 5'b00000,
    OP_OR    = 5'b00001,
    OP_ADD   = 5'b00010,
    OP_SLT   = 5'b00011,
    OP_SLL   = 5'b00100,
    OP_SRL   = 5'b00101,
    OP_SRA   = 5'b00110,
    OP_XOR   = 5'b00111,
    OP_NOR   = 5'b01001,
    OP_SUB   = 5'b01010,
    OP_SLTU  = 5'b01011,
    OP_MFHI  = 5'b01100,
    OP_MFLO  = 5'b01101,
    OP_MULT  = 5'b10000,
    OP_MULTU = 5'b10001,
    OP_DIV   = 5'b10010,
    OP_DIVU  = 5'b10011,
    OP_MTHI  = 5'b10100,
    OP_MTLO  = 5'b10101
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_t;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative radix-2 multiply/divide engine owning the HI/LO registers.
// Works on operand magnitudes and applies sign correction in a final FIX cycle.
module muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int SHW = $clog2(WIDTH);

  md_state_t          state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  // Operation context captured at launch; no reset needed, only valid while busy.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               b_zero_q, b_zero_d;

  logic               sgn, a_neg, b_neg, qbit;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, rem_sh, rem_sub;
  logic [2*WIDTH-1:0] prod;

  // Next-state, datapath step and HI/LO update for the IDLE/RUN/FIX sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    a_raw_d  = a_raw_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    b_zero_d = b_zero_q;
    sgn      = 1'b0;
    a_neg    = 1'b0;
    b_neg    = 1'b0;
    a_mag    = '0;
    b_mag    = '0;
    mul_sum  = '0;
    rem_sh   = '0;
    rem_sub  = '0;
    qbit     = 1'b0;
    prod     = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MTHI: begin
              hi_d   = a;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = a;
              done_d = 1'b1;
            end
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              sgn      = (op == OP_MULT) || (op == OP_DIV);
              a_neg    = sgn & a[WIDTH-1];
              b_neg    = sgn & b[WIDTH-1];
              a_mag    = a_neg ? (~a + 1'b1) : a;
              b_mag    = b_neg ? (~b + 1'b1) : b;
              is_div_d = (op == OP_DIV) || (op == OP_DIVU);
              neg_lo_d = a_neg ^ b_neg;
              // Remainder takes the dividend's sign; unused for multiply.
              neg_hi_d = a_neg;
              b_zero_d = (b == '0);
              a_raw_d  = a;
              acc_d    = {{WIDTH{1'b0}}, a_mag};
              opnd_d   = b_mag;
              cnt_d    = '0;
              busy_d   = 1'b1;
              state_d  = RUN;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        if (is_div_q) begin
          // Restoring divide: partial remainder in the upper half, quotient shifts into the lower half.
          rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
          if (rem_sh >= {1'b0, opnd_q}) begin
            rem_sub = rem_sh - {1'b0, opnd_q};
            qbit    = 1'b1;
          end else begin
            rem_sub = rem_sh;
          end
          acc_d = {rem_sub[WIDTH-1:0], acc_q[WIDTH-2:0], qbit};
        end else begin
          // Shift-add multiply: multiplier consumed from the LSB, product grows from the top.
          mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
          acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIX: begin
        if (is_div_q) begin
          if (b_zero_q) begin
            lo_d  = '1;
            hi_d  = a_raw_q;
            dbz_d = 1'b1;
          end else begin
            lo_d = neg_lo_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
            hi_d = neg_hi_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
          end
        end else begin
          prod = neg_lo_q ? (~acc_q + 1'b1) : acc_q;
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Control and architectural HI/LO state; asynchronous reset aborts any operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  // Working accumulator and launch context.
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    opnd_q   <= opnd_d;
    a_raw_q  <= a_raw_d;
    is_div_q <= is_div_d;
    neg_lo_q <= neg_lo_d;
    neg_hi_q <= neg_hi_d;
    b_zero_q <= b_zero_d;
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: combinational single-cycle operations plus HI/LO access,
// with multiply/divide delegated to the iterative muldiv_seq engine.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       op,
  input  logic [SHW-1:0]   shamt,
  input  logic             start,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH-1:0]        hi_w, lo_w;

  assign a_s = a;
  assign b_s = b;

  muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .hi          (hi_w),
    .lo          (lo_w),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  // Single-cycle result select; multi-cycle and undefined codes yield zero.
  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_SLT:  y = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: y = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  y = b << shamt;
      OP_SRL:  y = b >> shamt;
      OP_SRA:  y = b_s >>> shamt;
      OP_MFHI: y = hi_w;
      OP_MFLO: y = lo_w;
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);
  assign hi   = hi_w;
  assign lo   = lo_w;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv (WIDTH=32) with hand-computed expectations.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic [4:0]  op = 5'b00000;
  logic [4:0]  shamt = '0;
  logic        start = 1'b0;
  logic [31:0] y, hi, lo;
  logic        zero, busy, done, div_by_zero;

  int checks = 0;
  int errors = 0;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .op(op), .shamt(shamt), .start(start),
    .y(y), .zero(zero), .hi(hi), .lo(lo), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic comb(input logic [4:0] o, input logic [31:0] x, input logic [31:0] z,
                      input logic [4:0] sh);
    op = o; a = x; b = z; shamt = sh;
    #1;
  endtask

  // Launch at edge 0; returns the edge index where done appeared (0 = never) and whether busy held.
  task automatic md_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] z,
                       output int lat, output logic busy_ok);
    @(negedge clk);
    op = o; a = x; b = z; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_ok = busy;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  int   lat;
  logic bok;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    reset = 1'b0;

    // Single-cycle operations
    comb(5'b00010, 32'd7, 32'hFFFF_FFFD, 0);  chk("add", y, 32'd4);
    comb(5'b01010, 32'd5, 32'd5, 0);          chk("sub", y, 0); chk("sub_zero", zero, 1);
    comb(5'b00011, 32'hFFFF_FFFF, 32'd1, 0);  chk("slt", y, 1); chk("slt_zero", zero, 0);
    comb(5'b01011, 32'hFFFF_FFFF, 32'd1, 0);  chk("sltu", y, 0);
    comb(5'b00110, 0, 32'h8000_0000, 4);      chk("sra", y, 32'hF800_0000);
    comb(5'b00101, 0, 32'h8000_0000, 4);      chk("srl", y, 32'h0800_0000);
    comb(5'b00100, 0, 32'h0000_00F1, 8);      chk("sll", y, 32'h0000_F100);
    comb(5'b00000, 32'hF0F0_1234, 32'h0FF0_FF00, 0); chk("and", y, 32'h00F0_1200);
    comb(5'b00001, 32'hF000_0001, 32'h0000_0F00, 0); chk("or", y, 32'hF000_0F01);
    comb(5'b00111, 32'hFFFF_0000, 32'hF0F0_F0F0, 0); chk("xor", y, 32'h0F0F_F0F0);
    comb(5'b01001, 32'hFFFF_0000, 32'h0000_00FF, 0); chk("nor", y, 32'h0000_FF00);
    comb(5'b01000, 32'd3, 32'd4, 0);          chk("undef_y", y, 0);
    comb(5'b10000, 32'd3, 32'd4, 0);          chk("mult_y", y, 0);

    // start with a single-cycle op does nothing
    @(negedge clk); op = 5'b00010; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("sc_start_busy", busy, 0);
    chk("sc_start_done", done, 0);

    // MULT -3*5
    md_op(5'b10000, 32'hFFFF_FFFD, 32'd5, lat, bok);
    chk("mult_lat", lat, 33); chk("mult_busy", bok, 1);
    chk("mult_hi", hi, 32'hFFFF_FFFF); chk("mult_lo", lo, 32'hFFFF_FFF1);
    chk("mult_dbz", div_by_zero, 0); chk("mult_busy_end", busy, 0);
    @(posedge clk); #1;
    chk("done_pulse", done, 0);

    md_op(5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bok);
    chk("multu_lat", lat, 33);
    chk("multu_hi", hi, 32'hFFFF_FFFE); chk("multu_lo", lo, 32'h0000_0001);

    md_op(5'b10010, 32'hFFFF_FFF9, 32'd2, lat, bok);
    chk("div_lat", lat, 33);
    chk("div_lo", lo, 32'hFFFF_FFFD); chk("div_hi", hi, 32'hFFFF_FFFF);

    md_op(5'b10010, 32'd7, 32'hFFFF_FFFE, lat, bok);
    chk("div2_lo", lo, 32'hFFFF_FFFD); chk("div2_hi", hi, 32'd1);

    md_op(5'b10011, 32'd100, 32'd7, lat, bok);
    chk("divu_lat", lat, 33); chk("divu_busy", bok, 1);
    chk("divu_lo", lo, 32'd14); chk("divu_hi", hi, 32'd2); chk("divu_dbz", div_by_zero, 0);

    md_op(5'b10010, 32'h8000_0000, 32'hFFFF_FFFF, lat, bok);
    chk("divmin_lo", lo, 32'h8000_0000); chk("divmin_hi", hi, 0);

    md_op(5'b10010, 32'h0000_1234, 32'd0, lat, bok);
    chk("dbz_lat", lat, 33);
    chk("dbz_lo", lo, 32'hFFFF_FFFF); chk("dbz_hi", hi, 32'h0000_1234);
    chk("dbz_flag", div_by_zero, 1);
    @(posedge clk); #1;
    chk("dbz_pulse", div_by_zero, 0);

    // Second start while busy is ignored
    @(negedge clk); op = 5'b10000; a = 32'hFFFF_FFFD; b = 32'd5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); op = 5'b10011; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = 0;
    for (int i = 6; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk("hz_lat", lat, 33);
    chk("hz_hi", hi, 32'hFFFF_FFFF); chk("hz_lo", lo, 32'hFFFF_FFF1);
    @(posedge clk); #1;
    chk("hz_no_second", busy, 0);

    // Reset mid-RUN
    @(negedge clk); op = 5'b10001; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #2; reset = 1'b1; #1;
    chk("rstrun_busy", busy, 0);
    chk("rstrun_hi", hi, 0); chk("rstrun_lo", lo, 0);
    @(negedge clk); reset = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) lat = i;
    end
    chk("rstrun_no_done", lat, 0);

    // MTLO / MTHI and readback
    @(negedge clk); op = 5'b10101; a = 32'h5555_AAAA; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("mtlo_done", done, 1); chk("mtlo_lo", lo, 32'h5555_AAAA);
    @(negedge clk); op = 5'b10100; a = 32'hDEAD_BEEF; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("mthi_done", done, 1); chk("mthi_hi", hi, 32'hDEAD_BEEF);
    chk("mthi_lo_kept", lo, 32'h5555_AAAA); chk("mthi_busy", busy, 0);
    comb(5'b01100, 0, 0, 0); chk("mfhi", y, 32'hDEAD_BEEF);
    comb(5'b01101, 0, 0, 0); chk("mflo", y, 32'h5555_AAAA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
